// File: rtl/iob_jbi_rptr_pipe.sv
// iob_jbi_rptr_pipe
// Cascade of STAGES two-entry skid repeaters. Every stage registers its
// ready and valid, so no combinational path crosses a stage boundary and
// long routes can be split without losing throughput. Also flags an upstream
// source that withdraws or alters a stalled transfer.
module iob_jbi_rptr_pipe #(
  parameter int WIDTH  = 136,
  parameter int STAGES = 2,
  localparam int CW    = $clog2(2*STAGES+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat,
  output logic [CW-1:0]    occ,
  output logic             err_proto
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } st_e;

  // Handshake chain: index k is the input side of stage k, index k+1 its output.
  logic [STAGES:0] vld_c;
  logic [STAGES:0] rdy_c;
  logic [WIDTH-1:0] dat_c [STAGES+1];
  logic [1:0]       cnt_d [STAGES];
  logic [CW-1:0]    occ_d;

  assign vld_c[0]      = in_vld;
  assign dat_c[0]      = in_dat;
  assign rdy_c[STAGES] = out_rdy;
  assign in_rdy        = rdy_c[0];
  assign out_vld       = vld_c[STAGES];
  assign out_dat       = dat_c[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    st_e              st_q;
    st_e              st_d;
    logic             rdy_q;
    logic             vld_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] skid_q;
    logic             push;
    logic             pop;

    assign push         = vld_c[k] & rdy_q;
    assign pop          = vld_q & rdy_c[k+1];
    assign vld_c[k+1]   = vld_q;
    assign rdy_c[k]     = rdy_q;
    assign dat_c[k+1]   = head_q;
    assign cnt_d[k]     = (st_d == TWO) ? 2'd2 : (st_d == ONE) ? 2'd1 : 2'd0;

    // Next-state of this stage; a push while full is dropped (rdy is low there).
    always_comb begin
      // NOTE: default assignment first so every path assigns st_d and no latch is inferred.
      st_d = st_q;
      unique case (st_q)
        EMPTY: if (push) st_d = ONE;
        ONE: begin
          if (push && !pop)      st_d = TWO;
          else if (pop && !push) st_d = EMPTY;
        end
        TWO:     if (pop) st_d = ONE;
        default: st_d = EMPTY;
      endcase
    end

    // State, registered handshake flags and the two data slots of this stage.
    always_ff @(posedge clk) begin
      if (rst) begin
        st_q   <= EMPTY;
        rdy_q  <= 1'b0;
        vld_q  <= 1'b0;
        // NOTE: the data slots are reset so out_dat reads zero during reset; they are only two words per stage.
        head_q <= '0;
        skid_q <= '0;
      end else begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        st_q  <= st_d;
        rdy_q <= (st_d != TWO);
        vld_q <= (st_d != EMPTY);
        case (st_q)
          EMPTY: if (push) head_q <= dat_c[k];
          ONE: begin
            if (push && pop) head_q <= dat_c[k];
            else if (push)   skid_q <= dat_c[k];
          end
          TWO:     if (pop) head_q <= skid_q;
          default: ;
        endcase
      end
    end
  end

  // Total occupancy is the sum of the next per-stage entry counts.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < STAGES; i++) occ_d = occ_d + CW'(cnt_d[i]);
  end

  // Occupancy register, updated on the same edge as the stage states.
  always_ff @(posedge clk) begin
    if (rst) occ <= '0;
    else     occ <= occ_d;
  end

  logic             stall_q;
  logic [WIDTH-1:0] stall_dat_q;

  // Sticky protocol flag: a stalled offer must keep in_vld and in_dat until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q     <= 1'b0;
      stall_dat_q <= '0;
      err_proto   <= 1'b0;
    end else begin
      stall_q     <= in_vld & ~in_rdy;
      stall_dat_q <= in_dat;
      if (stall_q && (!in_vld || in_dat != stall_dat_q)) err_proto <= 1'b1;
    end
  end

endmodule
